// File: rtl/cond_unit_e.sv
`default_nettype none
// ============================================================================
// Module   : cond_unit_e
// Purpose  : Execute-stage ARM condition unit: NZCV + sticky Q flag register,
//            condition evaluation, side-effect gating and E->M control register.
// Revision : 1.0 - initial release
// ============================================================================
module cond_unit_e (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ALUFlags,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWriteE,
  input  logic       QWriteE,
  input  logic       QClrE,
  input  logic       ValidE,
  input  logic       StallM,
  input  logic       PCSrcE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       MemtoRegE,
  output logic       CondExE,
  output logic       BranchTakenE,
  output logic [4:0] Flags,
  output logic       ValidM,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       MemtoRegM
);

  localparam logic [4:0] c_flags_rst = 5'b00000;

  logic [4:0] flags_q, flags_d;
  logic       valid_m_q, valid_m_d;
  logic       reg_write_m_q, reg_write_m_d;
  logic       mem_write_m_q, mem_write_m_d;
  logic       memto_reg_m_q, memto_reg_m_d;

  logic w_n, w_z, w_c, w_v;
  logic w_cond_ex;
  logic w_adv;
  logic w_exec;

  assign {w_n, w_z, w_c, w_v} = flags_q[4:1];

  // Evaluated against committed flags only; no bypass from ALUFlags.
  always_comb begin
    w_cond_ex = 1'b0;
    case (CondE)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      default: w_cond_ex = 1'b1;
    endcase
  end

  assign w_adv        = ValidE & ~StallM;
  assign w_exec       = w_adv & w_cond_ex;
  assign CondExE      = w_cond_ex;
  assign BranchTakenE = PCSrcE & w_exec;

  always_comb begin
    flags_d = flags_q;
    if (w_exec) begin
      if (FlagWriteE[1]) flags_d[4:3] = ALUFlags[4:3];
      if (FlagWriteE[0]) flags_d[2:1] = ALUFlags[2:1];
      // Q is sticky: a non-saturating QADD/QSUB leaves it alone, clear wins.
      if (QClrE)                       flags_d[0] = 1'b0;
      else if (QWriteE && ALUFlags[0]) flags_d[0] = 1'b1;
    end
  end

  always_comb begin
    valid_m_d     = valid_m_q;
    reg_write_m_d = reg_write_m_q;
    mem_write_m_d = mem_write_m_q;
    memto_reg_m_d = memto_reg_m_q;
    if (!StallM) begin
      valid_m_d     = ValidE;
      reg_write_m_d = ValidE & RegWriteE & w_cond_ex;
      mem_write_m_d = ValidE & MemWriteE & w_cond_ex;
      memto_reg_m_d = ValidE & MemtoRegE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q       <= c_flags_rst;
      valid_m_q     <= 1'b0;
      reg_write_m_q <= 1'b0;
      mem_write_m_q <= 1'b0;
      memto_reg_m_q <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      valid_m_q     <= valid_m_d;
      reg_write_m_q <= reg_write_m_d;
      mem_write_m_q <= mem_write_m_d;
      memto_reg_m_q <= memto_reg_m_d;
    end
  end

  assign Flags     = flags_q;
  assign ValidM    = valid_m_q;
  assign RegWriteM = reg_write_m_q;
  assign MemWriteM = mem_write_m_q;
  assign MemtoRegM = memto_reg_m_q;

endmodule
`default_nettype wire

// File: tb/tb_cond_unit_e.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_unit_e
// Purpose  : Self-checking bench for cond_unit_e with an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_unit_e;

  logic       clk;
  logic       reset;
  logic [4:0] ALUFlags;
  logic [3:0] CondE;
  logic [1:0] FlagWriteE;
  logic       QWriteE, QClrE, ValidE, StallM;
  logic       PCSrcE, RegWriteE, MemWriteE, MemtoRegE;
  logic       CondExE, BranchTakenE;
  logic [4:0] Flags;
  logic       ValidM, RegWriteM, MemWriteM, MemtoRegM;

  cond_unit_e dut (
    .clk(clk), .reset(reset), .ALUFlags(ALUFlags), .CondE(CondE),
    .FlagWriteE(FlagWriteE), .QWriteE(QWriteE), .QClrE(QClrE),
    .ValidE(ValidE), .StallM(StallM), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE), .Flags(Flags),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .MemtoRegM(MemtoRegM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] m_flags;
  logic [3:0] m_m;          // {ValidM, RegWriteM, MemWriteM, MemtoRegM}
  logic [8:0] sb[$];        // {Flags, M outputs} expected after the edge

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic cond_f(input logic [4:0] f, input logic [3:0] cc);
    logic n, z, c, v, b;
    {n, z, c, v} = f[4:1];
    case (cc[3:1])
      3'd0: b = z;
      3'd1: b = c;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = c & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: b = 1'b0;
    endcase
    return (cc[3:1] == 3'd7) ? 1'b1 : (b ^ cc[0]);
  endfunction

  // Drive one Execute cycle, check combinational outputs, then check registered results.
  task automatic step(input logic [3:0] cc, input logic [1:0] fw, input logic [4:0] alu,
                      input logic qw, input logic qc, input logic v, input logic st,
                      input logic pc, input logic rw, input logic mw, input logic mtr);
    logic       c;
    logic [4:0] nf;
    logic [3:0] nm;
    logic [8:0] e;
    CondE = cc; FlagWriteE = fw; ALUFlags = alu; QWriteE = qw; QClrE = qc;
    ValidE = v; StallM = st; PCSrcE = pc; RegWriteE = rw; MemWriteE = mw; MemtoRegE = mtr;
    #1;
    c = cond_f(m_flags, cc);
    check("condex", {8'd0, CondExE}, {8'd0, c});
    check("branch", {8'd0, BranchTakenE}, {8'd0, pc & c & v & ~st});
    nf = m_flags;
    if (v && !st && c) begin
      if (fw[1]) nf[4:3] = alu[4:3];
      if (fw[0]) nf[2:1] = alu[2:1];
      if (qc) nf[0] = 1'b0;
      else if (qw && alu[0]) nf[0] = 1'b1;
    end
    if (st)     nm = m_m;
    else if (v) nm = {1'b1, rw & c, mw & c, mtr};
    else        nm = 4'b0000;
    sb.push_back({nf, nm});
    m_flags = nf;
    m_m     = nm;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("flags", {4'd0, Flags}, {4'd0, e[8:4]});
    check("mregs", {5'd0, ValidM, RegWriteM, MemWriteM, MemtoRegM}, {5'd0, e[3:0]});
  endtask

  initial begin
    reset = 1'b1;
    CondE = 4'd0; FlagWriteE = 2'd0; ALUFlags = 5'd0; QWriteE = 1'b0; QClrE = 1'b0;
    ValidE = 1'b0; StallM = 1'b0; PCSrcE = 1'b0; RegWriteE = 1'b0; MemWriteE = 1'b0;
    MemtoRegE = 1'b0;
    m_flags = 5'd0;
    m_m     = 4'd0;
    @(posedge clk);
    #1;
    check("rst_flags", {4'd0, Flags}, 9'd0);
    check("rst_m", {5'd0, ValidM, RegWriteM, MemWriteM, MemtoRegM}, 9'd0);
    reset = 1'b0;

    // Partial flag writes from all-zero flags.
    step(4'b1110, 2'b01, 5'b11110, 0, 0, 1, 0, 0, 1, 0, 1);
    check("pfw_cv", {4'd0, Flags}, {4'd0, 5'b00110});
    step(4'b1110, 2'b10, 5'b01000, 0, 0, 1, 0, 0, 0, 1, 0);
    check("pfw_nz", {4'd0, Flags}, {4'd0, 5'b01110});

    // Sticky Q.
    step(4'b1110, 2'b00, 5'b00001, 1, 0, 1, 0, 0, 1, 0, 0);
    check("q_set", {8'd0, Flags[0]}, 9'd1);
    step(4'b1110, 2'b00, 5'b00000, 1, 0, 1, 0, 0, 1, 0, 0);
    check("q_keep", {8'd0, Flags[0]}, 9'd1);
    step(4'b1110, 2'b00, 5'b00001, 1, 1, 1, 0, 0, 1, 0, 0);
    check("q_clrwins", {8'd0, Flags[0]}, 9'd0);
    step(4'b1110, 2'b00, 5'b00001, 1, 0, 1, 0, 0, 0, 0, 0);
    step(4'b1110, 2'b10, 5'b01000, 0, 0, 1, 0, 0, 0, 0, 0);   // Z=1
    step(4'b0001, 2'b00, 5'b00000, 0, 1, 1, 0, 0, 0, 0, 0);   // NE fails
    check("q_failclr", {8'd0, Flags[0]}, 9'd1);

    // Condition-fail gating with Z=1.
    step(4'b0001, 2'b11, 5'b10110, 0, 0, 1, 0, 1, 1, 1, 0);
    check("fail_m", {5'd0, ValidM, RegWriteM, MemWriteM, MemtoRegM}, {5'd0, 4'b1000});

    // CMP held three cycles, then released, then a dependent BEQ.
    repeat (3) step(4'b1110, 2'b11, 5'b00100, 0, 0, 1, 1, 1, 1, 0, 0);
    step(4'b1110, 2'b11, 5'b00100, 0, 0, 1, 0, 0, 0, 0, 0);
    check("stall_rel", {4'd0, Flags}, {4'd0, 5'b00101});
    step(4'b0000, 2'b00, 5'b00000, 0, 0, 1, 0, 1, 0, 0, 0);
    step(4'b0000, 2'b11, 5'b11111, 0, 0, 0, 0, 1, 1, 1, 1);   // bubble
    check("bubble_v", {8'd0, ValidM}, 9'd0);

    // Condition sweep: all NZCV x all CondE, DUT frozen by stall.
    for (int f = 0; f < 16; f++) begin
      step(4'b1110, 2'b11, {f[3:0], 1'b0}, 0, 0, 1, 0, 0, 0, 0, 0);
      ValidE = 1'b0; StallM = 1'b1; PCSrcE = 1'b1;
      for (int cc = 0; cc < 16; cc++) begin
        CondE = cc[3:0];
        #1;
        check("sweep", {8'd0, CondExE}, {8'd0, cond_f(m_flags, cc[3:0])});
      end
      @(posedge clk);
      #1;
    end
    step(4'b1110, 2'b11, 5'b10010, 0, 0, 1, 0, 0, 0, 0, 0);   // NZCV=1001
    step(4'b1010, 2'b00, 5'b00000, 0, 0, 0, 1, 0, 0, 0, 0);
    check("ge_1001", {8'd0, CondExE}, 9'd1);
    step(4'b1011, 2'b00, 5'b00000, 0, 0, 0, 1, 0, 0, 0, 0);
    check("lt_1001", {8'd0, CondExE}, 9'd0);
    step(4'b1100, 2'b00, 5'b00000, 0, 0, 0, 1, 0, 0, 0, 0);
    check("gt_1001", {8'd0, CondExE}, 9'd1);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 31),
           $urandom_range(0, 1), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1));
    end

    // Force everything high, then reset asynchronously mid-stall.
    step(4'b1110, 2'b11, 5'b11111, 1, 0, 1, 0, 0, 1, 1, 1);
    check("pre_rst", {4'd0, Flags}, {4'd0, 5'b11111});
    ValidE = 1'b1; StallM = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check("arst_flags", {4'd0, Flags}, 9'd0);
    check("arst_m", {5'd0, ValidM, RegWriteM, MemWriteM, MemtoRegM}, 9'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_flags = 5'd0;
    m_m     = 4'd0;
    step(4'b0000, 2'b00, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_eq", {8'd0, CondExE}, 9'd0);
    step(4'b0001, 2'b00, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_ne", {8'd0, CondExE}, 9'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
